// File: rtl/clock_reset_sequencer.sv
// clock_reset_sequencer: MMCM reset/lock sequencer with retry, fault and downstream domain reset release.
// Define CLOCK_RESET_SEQ_LOSS_COUNTER_EN to build the saturating lock_loss_count; otherwise it is tied to 0.
module clock_reset_sequencer #(
   parameter int MMCM_RST_CYCLES = 8,
   parameter int LOCK_TIMEOUT    = 1000,
   parameter int STABLE_CYCLES   = 64,
   parameter int MAX_RETRIES     = 3
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       mmcm_locked,
   input  logic       relock_req,
   output logic       mmcm_rst,
   output logic       domain_rst,
   output logic       ready,
   output logic       fault,
   output logic [3:0] retry_count,
   output logic [7:0] lock_loss_count
);
   localparam int MAX_A   = MMCM_RST_CYCLES > LOCK_TIMEOUT ? MMCM_RST_CYCLES : LOCK_TIMEOUT;
   localparam int CNT_MAX = MAX_A > STABLE_CYCLES ? MAX_A : STABLE_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] RST_LAST    = CW'(MMCM_RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
   typedef enum logic [2:0] {RESET_MMCM, WAIT_LOCK, STABLE, RUN, FAULT} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic          locked_m, locked_s;
   // Every state's outputs are set on the edge that enters it, so outputs track state exactly.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         locked_m    <= 1'b0;
         locked_s    <= 1'b0;
         state       <= RESET_MMCM;
         cnt         <= '0;
         mmcm_rst    <= 1'b1;
         domain_rst  <= 1'b1;
         ready       <= 1'b0;
         fault       <= 1'b0;
         retry_count <= '0;
      end else begin
         locked_m <= mmcm_locked;
         locked_s <= locked_m;
         case (state)
            RESET_MMCM: begin
               if (cnt == RST_LAST) begin
                  state    <= WAIT_LOCK;
                  cnt      <= '0;
                  mmcm_rst <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WAIT_LOCK: begin
               if (relock_req) begin
                  state    <= RESET_MMCM;
                  cnt      <= '0;
                  mmcm_rst <= 1'b1;
               end else if (locked_s) begin
                  state <= STABLE;
                  cnt   <= '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  cnt      <= '0;
                  mmcm_rst <= 1'b1;
                  if (retry_count == 4'(MAX_RETRIES)) begin
                     state <= FAULT;
                     fault <= 1'b1;
                  end else begin
                     state       <= RESET_MMCM;
                     retry_count <= retry_count + 4'd1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STABLE: begin
               if (relock_req) begin
                  state    <= RESET_MMCM;
                  cnt      <= '0;
                  mmcm_rst <= 1'b1;
               end else if (!locked_s) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == STABLE_LAST) begin
                  state       <= RUN;
                  cnt         <= '0;
                  domain_rst  <= 1'b0;
                  ready       <= 1'b1;
                  retry_count <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RUN: begin
               if (!locked_s || relock_req) begin
                  state      <= RESET_MMCM;
                  cnt        <= '0;
                  mmcm_rst   <= 1'b1;
                  domain_rst <= 1'b1;
                  ready      <= 1'b0;
               end
            end
            FAULT: begin
               mmcm_rst   <= 1'b1;
               domain_rst <= 1'b1;
               ready      <= 1'b0;
            end
            default: begin
               state      <= RESET_MMCM;
               cnt        <= '0;
               mmcm_rst   <= 1'b1;
               domain_rst <= 1'b1;
               ready      <= 1'b0;
            end
         endcase
      end
   end
`ifdef CLOCK_RESET_SEQ_LOSS_COUNTER_EN
   // A lock drop in RUN counts even when relock_req arrives in the same cycle.
   always_ff @(posedge clk_in) begin
      if (rst)
         lock_loss_count <= '0;
      else if (state == RUN && !locked_s && lock_loss_count != 8'hFF)
         lock_loss_count <= lock_loss_count + 8'd1;
   end
`else
   assign lock_loss_count = '0;
`endif
endmodule
